// File: rtl/door_pkg.sv
// Shared definitions for the door access controller: state codes, grant rule
// and default timing constants.
package door_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UNLOCK  = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } door_state_e;

  localparam int DEF_UNLOCK_CYC  = 8;
  localparam int DEF_AJAR_CYC    = 16;
  localparam int DEF_MAX_FAIL    = 3;
  localparam int DEF_LOCKOUT_CYC = 20;

  // A remote release is sufficient on its own; otherwise a PIN plus one physical token.
  function automatic logic grant_fn(input logic pin_ok, input logic key_ok,
                                    input logic card_ok, input logic remote_ok);
    return remote_ok | (pin_ok & (key_ok | card_ok));
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Timer holds at most max-1, so clog2(max) bits; never narrower than one bit.
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = max3(a, b, c);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/door_access_ctrl_timer.sv
// Loadable down-counter shared by all timed FSM states; saturates at zero.
module door_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/door_access_ctrl.sv
// Door strike controller: credential decision, unlock window, door-ajar
// supervision and failed-attempt lockout. All outputs are registered.
module door_access_ctrl
  import door_pkg::*;
#(
  parameter int UNLOCK_CYC  = DEF_UNLOCK_CYC,
  parameter int AJAR_CYC    = DEF_AJAR_CYC,
  parameter int MAX_FAIL    = DEF_MAX_FAIL,
  parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       pin_ok,
  input  logic       key_ok,
  input  logic       card_ok,
  input  logic       remote_ok,
  input  logic       door_open,
  output logic       unlock,
  output logic       granted,
  output logic       denied,
  output logic       locked_out,
  output logic       ajar_alarm,
  output logic [1:0] state
);

  localparam int TMR_W = tmr_width(UNLOCK_CYC, AJAR_CYC, LOCKOUT_CYC);
  localparam int FC_W  = $clog2(MAX_FAIL + 1);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_UNLOCK  = ST_UNLOCK;
  localparam logic [1:0] S_OPEN    = ST_OPEN;
  localparam logic [1:0] S_LOCKOUT = ST_LOCKOUT;

  localparam logic [TMR_W-1:0] UNLOCK_LD  = TMR_W'(UNLOCK_CYC - 1);
  localparam logic [TMR_W-1:0] AJAR_LD    = TMR_W'(AJAR_CYC - 1);
  localparam logic [TMR_W-1:0] LOCKOUT_LD = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [FC_W-1:0]  FAIL_LIM   = FC_W'(MAX_FAIL);

  logic [1:0]       state_nxt;
  logic [FC_W-1:0]  fail_cnt;
  logic [FC_W-1:0]  fail_nxt;
  logic [FC_W-1:0]  fail_inc;
  logic             granted_nxt;
  logic             denied_nxt;
  logic             alarm_nxt;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;

  door_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign fail_inc = fail_cnt + 1'b1;

  always_comb begin
    state_nxt   = state;
    fail_nxt    = fail_cnt;
    granted_nxt = 1'b0;
    denied_nxt  = 1'b0;
    alarm_nxt   = ajar_alarm;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_dec     = 1'b0;
    case (state)
      S_IDLE: begin
        alarm_nxt = 1'b0;
        if (req) begin
          if (grant_fn(pin_ok, key_ok, card_ok, remote_ok)) begin
            state_nxt   = S_UNLOCK;
            granted_nxt = 1'b1;
            fail_nxt    = '0;
            tmr_load    = 1'b1;
            tmr_val     = UNLOCK_LD;
          end else begin
            denied_nxt = 1'b1;
            if (fail_inc == FAIL_LIM) begin
              state_nxt = S_LOCKOUT;
              fail_nxt  = '0;
              tmr_load  = 1'b1;
              tmr_val   = LOCKOUT_LD;
            end else begin
              fail_nxt = fail_inc;
            end
          end
        end
      end
      S_UNLOCK: begin
        // Door opening wins over a simultaneous window expiry.
        if (door_open) begin
          state_nxt = S_OPEN;
          tmr_load  = 1'b1;
          tmr_val   = AJAR_LD;
        end else if (tmr_zero) begin
          state_nxt = S_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_OPEN: begin
        if (!door_open) begin
          state_nxt = S_IDLE;
          alarm_nxt = 1'b0;
        end else if (tmr_zero) begin
          alarm_nxt = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        if (tmr_zero) begin
          state_nxt = S_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      fail_cnt   <= '0;
      unlock     <= 1'b0;
      granted    <= 1'b0;
      denied     <= 1'b0;
      locked_out <= 1'b0;
      ajar_alarm <= 1'b0;
    end else begin
      state      <= state_nxt;
      fail_cnt   <= fail_nxt;
      unlock     <= (state_nxt == S_UNLOCK);
      granted    <= granted_nxt;
      denied     <= denied_nxt;
      locked_out <= (state_nxt == S_LOCKOUT);
      ajar_alarm <= alarm_nxt;
    end
  end

endmodule

// File: tb/tb_door_access_ctrl.sv
// Directed bench for door_access_ctrl: a vector table for single-cycle behaviour
// plus hand-written multi-cycle sequences (expiry, ajar, lockout, async reset).
module tb_door_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req, pin_ok, key_ok, card_ok, remote_ok, door_open;
  logic       unlock, granted, denied, locked_out, ajar_alarm;
  logic [1:0] state;

  int n_cmp  = 0;
  int n_fail = 0;

  door_access_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .pin_ok     (pin_ok),
    .key_ok     (key_ok),
    .card_ok    (card_ok),
    .remote_ok  (remote_ok),
    .door_open  (door_open),
    .unlock     (unlock),
    .granted    (granted),
    .denied     (denied),
    .locked_out (locked_out),
    .ajar_alarm (ajar_alarm),
    .state      (state)
  );

  always #5 clk = ~clk;

  // exp = {unlock, granted, denied, locked_out, ajar_alarm, state[1:0]}
  typedef struct {
    logic       req;
    logic       pin;
    logic       key;
    logic       card;
    logic       remote;
    logic       door;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic drive(input logic r, input logic p, input logic k,
                       input logic c, input logic m, input logic d);
    req = r; pin_ok = p; key_ok = k; card_ok = c; remote_ok = m; door_open = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [6:0] exp);
    logic [6:0] got;
    got = {unlock, granted, denied, locked_out, ajar_alarm, state};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {unl,gnt,den,lck,alm,st}=%b, expected %b", nm, got, exp);
    end
    n_cmp++;
    if ((granted & denied) !== 1'b0 || (unlock & locked_out) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_exclusive: got gnt&den=%b unl&lck=%b, expected 0 0",
               nm, granted & denied, unlock & locked_out);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0010000};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0010000};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1100001};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1000001};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000010};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1100001};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000010};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1100001};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset", 7'b0000000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].req, vecs[i].pin, vecs[i].key, vecs[i].card, vecs[i].remote, vecs[i].door);
      cyc();
      check($sformatf("vec[%0d]", i), vecs[i].exp);
    end

    // Unlock window expiry: vec[12] granted, strike held 8 cycles total.
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 8; i++) begin
      cyc();
      check($sformatf("unlock_hold[%0d]", i), 7'b1000001);
    end
    cyc();
    check("unlock_expire", 7'b0000000);

    // Door held ajar: alarm on the 16th edge in OPEN, held, cleared on close.
    drive(1, 0, 0, 0, 1, 0);
    cyc();
    check("ajar_grant", 7'b1100001);
    drive(0, 0, 0, 0, 0, 1);
    cyc();
    check("ajar_open", 7'b0000010);
    for (int i = 1; i < 16; i++) begin
      drive(i == 3, 1, 1, 0, 1, 1);
      cyc();
      check($sformatf("ajar_wait[%0d]", i), 7'b0000010);
    end
    cyc();
    check("ajar_alarm_rise", 7'b0000110);
    repeat (5) cyc();
    check("ajar_alarm_hold", 7'b0000110);
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    check("ajar_close", 7'b0000000);

    // Lockout after three consecutive denials; requests ignored meanwhile.
    for (int i = 1; i <= 2; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      cyc();
      check($sformatf("lock_deny[%0d]", i), 7'b0010000);
    end
    cyc();
    check("lock_enter", 7'b0011011);
    drive(1, 0, 0, 0, 1, 0);
    cyc();
    check("lock_ignore_req", 7'b0001011);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 2; i < 20; i++) begin
      cyc();
      if (i == 19) check("lock_last", 7'b0001011);
    end
    cyc();
    check("lock_exit", 7'b0000000);
    drive(1, 0, 0, 0, 1, 0);
    cyc();
    check("lock_regrant", 7'b1100001);
    drive(0, 0, 0, 0, 0, 0);
    repeat (8) cyc();
    check("lock_regrant_expire", 7'b0000000);

    // A grant between denials clears the count; the third following denial locks out.
    drive(1, 1, 0, 0, 0, 0);
    repeat (2) cyc();
    check("fr_deny2", 7'b0010000);
    drive(1, 1, 1, 0, 0, 0);
    cyc();
    check("fr_grant", 7'b1100001);
    drive(0, 0, 0, 0, 0, 0);
    repeat (8) cyc();
    drive(1, 1, 0, 0, 0, 0);
    cyc();
    check("fr_deny_a", 7'b0010000);
    cyc();
    check("fr_deny_b", 7'b0010000);
    cyc();
    check("fr_deny_c", 7'b0011011);
    drive(0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of an unlock window.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 1, 0);
    cyc();
    check("ar_grant", 7'b1100001);
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    check("ar_mid_unlock", 7'b1000001);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_async_drop", 7'b0000000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 0, 1, 0, 0);
    cyc();
    check("ar_regrant", 7'b1100001);
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    check("ar_regrant_hold", 7'b1000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/door_access_ctrl.md
Name: door_access_ctrl

Overview:
- Sequential controller that owns the door strike. It sequences the credential decision, unlock window, door-ajar supervision and failed-attempt lockout.
- Takes the four credential flags (pin, key, card, remote) plus a door position sensor. Drives a registered strike-release output and status/alarm flags.
- Sits between the credential front-ends and the lock actuator driver.

Parameters:
- UNLOCK_CYC, 8, cycles the strike stays released waiting for the door to open (>=1)
- AJAR_CYC, 16, cycles the door may stay open before alarm asserts (>=1)
- MAX_FAIL, 3, consecutive denied attempts that trigger lockout (>=1)
- LOCKOUT_CYC, 20, cycles requests are ignored once in lockout (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  1  attempt strobe; credential flags are sampled on cycles where req=1
- pin_ok  input  1  PIN credential valid
- key_ok  input  1  mechanical key credential valid
- card_ok  input  1  card credential valid
- remote_ok  input  1  remote-release credential valid
- door_open  input  1  door position sensor, 1 = door not closed; synchronous to clk
- unlock  output  1  strike release, registered
- granted  output  1  one-cycle pulse, attempt accepted
- denied  output  1  one-cycle pulse, attempt rejected
- locked_out  output  1  high while in LOCKOUT
- ajar_alarm  output  1  door held open too long
- state  output  2  current FSM state code, for debug

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE; all outputs 0.
  - fail_cnt = 0; timer = 0.
  - Reset mid-operation aborts immediately: unlock drops asynchronously and the alarm clears.
- Grant rule (combinational, evaluated only when req=1): grant = remote_ok | (pin_ok & (key_ok | card_ok)).
- State codes: IDLE=0, UNLOCK=1, OPEN=2, LOCKOUT=3.
- All outputs are registered. The response to req sampled at edge t is visible after edge t (latency 1).
- IDLE:
  - req & grant -> UNLOCK; granted=1; fail_cnt=0; timer loaded with UNLOCK_CYC-1.
  - req & !grant -> denied=1; fail_cnt+1.
    - If the incremented count equals MAX_FAIL -> LOCKOUT; timer loaded with LOCKOUT_CYC-1; fail_cnt=0.
    - Otherwise stay in IDLE.
  - door_open=1 while in IDLE (forced door): no state change.
- UNLOCK:
  - unlock=1.
  - door_open=1 -> OPEN; timer loaded with AJAR_CYC-1. Checked before timer expiry.
  - Else, timer==0 -> IDLE with unlock=0. Total strike time is exactly UNLOCK_CYC cycles.
  - Else timer decrements.
  - req in UNLOCK is ignored (no granted/denied pulse, fail_cnt unchanged).
- OPEN:
  - unlock=0, so the bolt re-arms for when the door closes.
  - door_open=0 -> IDLE; ajar_alarm clears on the same edge.
  - Else, timer==0 -> ajar_alarm=1 and held. The alarm first asserts after AJAR_CYC cycles in OPEN; remain in OPEN.
  - Else timer decrements.
  - req ignored.
- LOCKOUT:
  - locked_out=1.
  - req ignored: no pulses, no count.
  - timer==0 -> IDLE with locked_out=0.
  - Else timer decrements.
- fail_cnt:
  - Width $clog2(MAX_FAIL+1).
  - Cleared on grant, on entering LOCKOUT and on reset.
  - Never wraps.
- timer:
  - Width $clog2(max(UNLOCK_CYC, AJAR_CYC, LOCKOUT_CYC)).
  - Saturates at 0; it never underflows.
- granted and denied are never high in the same cycle.
- unlock and locked_out are never high together.

Decomposition:
- Shared package door_pkg holds:
  - state enum (IDLE/UNLOCK/OPEN/LOCKOUT, 2-bit)
  - grant function
  - default parameter constants
- One natural sub-module, door_timer: loadable down-counter with load value, load strobe, dec and zero flag. The FSM instantiates one shared timer, since states are mutually exclusive.

Test Plan:
- Valid grant: req=1, pin_ok=1, card_ok=1 at cycle 5 -> granted pulse at 6. unlock=1 for cycles 6..13. door_open stays 0 -> IDLE at 14, no alarm.
- Open and close: remote_ok grant, door_open=1 at 3 cycles after grant -> unlock drops next edge, state=OPEN. door_open=0 after 10 cycles -> IDLE, ajar_alarm never asserted.
- Ajar: grant, door held open 30 cycles -> ajar_alarm rises exactly 16 cycles after OPEN entry and stays high. Closing the door clears it on the next edge; state=IDLE.
- Lockout: three req with only pin_ok=1 -> three denied pulses; locked_out=1 after the third. A valid req during lockout gives no granted pulse. locked_out clears after 20 cycles; a subsequent valid req is granted.
- Fail reset: two denied attempts, then one grant, then two denied -> no lockout (fail_cnt cleared by the grant).
- Async reset: assert rst_n=0 mid-UNLOCK between clock edges -> unlock drops immediately, state=IDLE, all flags 0. After release, a fresh grant works normally.
